branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Parametrised branch/jump control unit between the instruction decoder and the program counter (fetch unit). It replaces the purely combinational jump-enable decode with a registered unit. Added behaviour:
- captures ALU compare flags into a flag register;
- evaluates unconditional and conditional (equal / greater-than) branches;
- looks up branch targets in a writable target table;
- issues a registered one-cycle `jump_en` with target;
- squashes wrong-path instructions for a programmable flush window;
- counts taken branches.

## Interface
Parameters:
- `OP_W`, 4, opcode width.
- `PC_W`, 13, program-counter and target width.
- `LUT_AW`, 4, target-table address width (2^LUT_AW entries).
- `FLUSH_CYCLES`, 1, cycles of wrong-path squash after a taken branch (legal range 1..7).
- `ODD_PC_ONLY`, 0, when 1 an unconditional jump is taken only if `PC[0]`=1.
- `OP_JMP`, 4'hE, opcode for the unconditional jump.
- `OP_BEQ`, 4'hC, opcode for branch-if-equal.
- `OP_BGT`, 4'hD, opcode for branch-if-greater.
- `OP_CMP`, 4'hB, opcode for compare (captures flags).
- `CNT_W`, 16, taken-branch counter width.

Ports:
- `CLK` in 1: the only clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `instr_valid` in 1: `OP`/`PC`/`tgt_idx` carry a real instruction this cycle.
- `OP` in OP_W: opcode.
- `PC` in PC_W: address of the current instruction.
- `tgt_idx` in LUT_AW: target-table index from the instruction field.
- `BEQ` in 1: ALU equal flag, meaningful with `OP_CMP`.
- `BGT` in 1: ALU greater flag, meaningful with `OP_CMP`.
- `lut_wr_en` in 1: target-table write strobe.
- `lut_wr_addr` in LUT_AW: target-table write address.
- `lut_wr_data` in PC_W: target-table write data.
- `jump_en` out 1: registered one-cycle pulse, load `jump_target` into the PC.
- `jump_target` out PC_W: registered branch target; valid while `jump_en`=1, otherwise holds its last value.
- `flush` out 1: current-cycle instruction is wrong-path and is ignored.
- `eq_flag` out 1: registered equal flag.
- `gt_flag` out 1: registered greater flag.
- `taken_cnt` out CNT_W: count of taken branches.

## Operation
An instruction is accepted when `instr_valid`=1 and `flush`=0. Non-accepted cycles change no flag, counter or branch state; the target table may still be written.

Flag capture:
- Accepted `OP_CMP` loads `eq_flag`<=`BEQ` and `gt_flag`<=`BGT`.
- Flags hold until the next accepted `OP_CMP`.
- Flags are not cleared by branches.

Taken decision (accepted instruction only):
- `OP_JMP`: taken if `ODD_PC_ONLY`=0, or if `PC[0]`=1.
- `OP_BEQ`: taken if `eq_flag`=1, using the flag value registered before this cycle.
- `OP_BGT`: taken if `gt_flag`=1.
- All other opcodes, including `OP_CMP`, are never taken.

On a taken decision, registered for the next cycle:
- `jump_en`<=1;
- `jump_target`<=table[`tgt_idx`];
- `taken_cnt`<=`taken_cnt`+1, wrapping modulo 2^CNT_W;
- the flush counter is loaded with FLUSH_CYCLES.

Target table:
- 2^LUT_AW x PC_W registers, cleared to 0 on reset.
- Write on a clock edge with `lut_wr_en`=1.
- Read is combinational with write bypass: if `lut_wr_en`=1 and `lut_wr_addr`=`tgt_idx` in the decision cycle, the target is `lut_wr_data`.

Flush state machine, with states IDLE and SQUASH:
- IDLE -> SQUASH on a taken decision; counter = FLUSH_CYCLES.
- In SQUASH, `flush`=1 and the counter decrements each cycle.
- SQUASH -> IDLE when the counter reaches 1 on a clock edge.
- A taken decision cannot occur in SQUASH, because no instruction is accepted there.

## Timing
- Decision in cycle n -> `jump_en`=1 in cycle n+1 only, with `jump_target` valid in n+1.
- `flush`=1 for cycles n+1 .. n+FLUSH_CYCLES.
- `flush` is a registered output, so it is high coincident with `jump_en`.
- `OP_CMP` in cycle n -> flags visible in n+1. A conditional branch in n+1 uses them with no bubble.
- `OP_CMP` and a branch in the same cycle is impossible (one opcode per cycle).
- Reset (synchronous, takes effect at the edge where `Reset`=1):
  - `jump_en`, `jump_target`, `flush`, `eq_flag`, `gt_flag`, `taken_cnt` = 0;
  - state = IDLE;
  - table cleared.
- Reset during SQUASH or with a decision pending aborts it: no `jump_en` appears after the reset edge.
- Reset has priority over `lut_wr_en` and `instr_valid`.

## Test plan
- Reset, then table[3]=0x0123 written.
  - `OP_JMP`, `tgt_idx`=3, `ODD_PC_ONLY`=0 -> next cycle `jump_en`=1, `jump_target`=0x0123, `flush`=1 for one cycle, `taken_cnt`=1.
- `OP_CMP` with `BEQ`=1, `BGT`=0, then `OP_BEQ` idx 2 (table[2]=0x0040) in the next cycle.
  - Required: taken, target 0x0040.
  - `OP_BGT` in the following accepted cycle -> not taken, `taken_cnt` unchanged.
- FLUSH_CYCLES=3: taken `OP_JMP` followed by three back-to-back `OP_JMP`s with `instr_valid`=1.
  - Required: exactly one `jump_en` pulse; `flush` high 3 cycles; the first jump after `flush` falls is taken.
- `ODD_PC_ONLY`=1:
  - `OP_JMP` at PC=0x0010 -> no jump;
  - `OP_JMP` at PC=0x0011 -> jump.
- Same-cycle write/read: `lut_wr_en`=1, addr 5, data 0x1ABC, with a taken `OP_JMP` idx 5 -> `jump_target`=0x1ABC.
- `Reset` asserted in the cycle a taken branch is decided -> next cycle `jump_en`=0, `flush`=0, flags 0, `taken_cnt`=0.
- CNT_W=4: 16 taken branches -> `taken_cnt` wraps to 0.

Source files
------------

// File: rtl/branch_ctrl.sv
// Registered branch/jump control between decoder and PC.
// Holds ALU flags, a writable target table and a wrong-path squash FSM.
module branch_ctrl #(
  parameter int             OP_W         = 4,
  parameter int             PC_W         = 13,
  parameter int             LUT_AW       = 4,
  parameter int             FLUSH_CYCLES = 1,
  parameter bit             ODD_PC_ONLY  = 1'b0,
  parameter logic [OP_W-1:0] OP_JMP      = 'hE,
  parameter logic [OP_W-1:0] OP_BEQ      = 'hC,
  parameter logic [OP_W-1:0] OP_BGT      = 'hD,
  parameter logic [OP_W-1:0] OP_CMP      = 'hB,
  parameter int             CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              instr_valid,
  input  logic [OP_W-1:0]   OP,
  input  logic [PC_W-1:0]   PC,
  input  logic [LUT_AW-1:0] tgt_idx,
  input  logic              BEQ,
  input  logic              BGT,
  input  logic              lut_wr_en,
  input  logic [LUT_AW-1:0] lut_wr_addr,
  input  logic [PC_W-1:0]   lut_wr_data,
  output logic              jump_en,
  output logic [PC_W-1:0]   jump_target,
  output logic              flush,
  output logic              eq_flag,
  output logic              gt_flag,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam int         DEPTH = 1 << LUT_AW;
  localparam logic [2:0] FC    = 3'(FLUSH_CYCLES);

  typedef enum logic {
    IDLE,
    SQUASH
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              eq_q, eq_d;
  logic              gt_q, gt_d;
  logic              jen_q, jen_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   lut_q [DEPTH];

  logic              accept;
  logic              taken;
  logic              is_cmp;
  logic [PC_W-1:0]   rd_tgt;
  logic              unused_pc;

  // Only PC[0] matters, and only for odd-PC jump gating.
  assign unused_pc = ^PC;

  assign flush  = (state_q == SQUASH);
  assign accept = instr_valid & ~flush;

  // Same-cycle write wins over the stored entry.
  assign rd_tgt = (lut_wr_en && lut_wr_addr == tgt_idx)
                ? lut_wr_data : lut_q[tgt_idx];

  always_comb begin
    taken  = 1'b0;
    is_cmp = 1'b0;
    unique case (1'b1)
      (OP == OP_JMP): taken  = ~ODD_PC_ONLY | PC[0];
      (OP == OP_BEQ): taken  = eq_q;
      (OP == OP_BGT): taken  = gt_q;
      (OP == OP_CMP): is_cmp = 1'b1;
      default: ;
    endcase
    taken  = taken & accept;
    is_cmp = is_cmp & accept;
  end

  always_comb begin
    eq_d  = eq_q;
    gt_d  = gt_q;
    jen_d = taken;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    if (is_cmp) begin
      eq_d = BEQ;
      gt_d = BGT;
    end
    if (taken) begin
      tgt_d = rd_tgt;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (taken) begin
          state_d = SQUASH;
          fcnt_d  = FC;
        end
      end
      SQUASH: begin
        if (fcnt_q <= 3'd1) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      jen_q   <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      jen_q   <= jen_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_wr_en) begin
      lut_q[lut_wr_addr] <= lut_wr_data;
    end
  end

  assign jump_en     = jen_q;
  assign jump_target = tgt_q;
  assign eq_flag     = eq_q;
  assign gt_flag     = gt_q;
  assign taken_cnt   = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: vector table through a scoreboard queue,
// plus hand sequences for flush window, odd-PC gating and counter wrap.
module tb_branch_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        instr_valid;
  logic [3:0]  OP;
  logic [12:0] PC;
  logic [3:0]  tgt_idx;
  logic        BEQ, BGT;
  logic        lut_wr_en;
  logic [3:0]  lut_wr_addr;
  logic [12:0] lut_wr_data;

  logic        jen0, fl0, eq0, gt0;
  logic [12:0] tgt0;
  logic [15:0] cnt0;
  logic        jen1, fl1, eq1, gt1;
  logic [12:0] tgt1;
  logic [15:0] cnt1;
  logic        jen2, fl2, eq2, gt2;
  logic [12:0] tgt2;
  logic [15:0] cnt2;
  logic        jen3, fl3, eq3, gt3;
  logic [12:0] tgt3;
  logic [3:0]  cnt3;

  always #5 CLK = ~CLK;

  branch_ctrl u0 (
    .CLK(CLK), .Reset(Reset), .instr_valid(instr_valid), .OP(OP),
    .PC(PC), .tgt_idx(tgt_idx), .BEQ(BEQ), .BGT(BGT),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .jump_en(jen0), .jump_target(tgt0),
    .flush(fl0), .eq_flag(eq0), .gt_flag(gt0), .taken_cnt(cnt0)
  );

  branch_ctrl #(.FLUSH_CYCLES(3)) u1 (
    .CLK(CLK), .Reset(Reset), .instr_valid(instr_valid), .OP(OP),
    .PC(PC), .tgt_idx(tgt_idx), .BEQ(BEQ), .BGT(BGT),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .jump_en(jen1), .jump_target(tgt1),
    .flush(fl1), .eq_flag(eq1), .gt_flag(gt1), .taken_cnt(cnt1)
  );

  branch_ctrl #(.ODD_PC_ONLY(1'b1)) u2 (
    .CLK(CLK), .Reset(Reset), .instr_valid(instr_valid), .OP(OP),
    .PC(PC), .tgt_idx(tgt_idx), .BEQ(BEQ), .BGT(BGT),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .jump_en(jen2), .jump_target(tgt2),
    .flush(fl2), .eq_flag(eq2), .gt_flag(gt2), .taken_cnt(cnt2)
  );

  branch_ctrl #(.CNT_W(4)) u3 (
    .CLK(CLK), .Reset(Reset), .instr_valid(instr_valid), .OP(OP),
    .PC(PC), .tgt_idx(tgt_idx), .BEQ(BEQ), .BGT(BGT),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .jump_en(jen3), .jump_target(tgt3),
    .flush(fl3), .eq_flag(eq3), .gt_flag(gt3), .taken_cnt(cnt3)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [3:0]  op;
    logic [3:0]  idx;
    logic        beq;
    logic        bgt;
    logic        we;
    logic [3:0]  wa;
    logic [12:0] wd;
  } stim_t;

  typedef struct {
    logic        jen;
    logic [12:0] tgt;
    logic        fl;
    logic        eq;
    logic        gt;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] CMP = 4'hB;
  localparam logic [3:0] BQ  = 4'hC;
  localparam logic [3:0] BG  = 4'hD;
  localparam logic [3:0] JMP = 4'hE;

  localparam int NV = 20;
  vec_t tbl [NV];
  exp_t sb [$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(
    input logic rst, input logic vld, input logic [3:0] op,
    input logic [3:0] idx, input logic beq, input logic bgt,
    input logic we, input logic [3:0] wa, input logic [12:0] wd,
    input logic ejen, input logic [12:0] etgt, input logic efl,
    input logic eeq, input logic egt, input logic [15:0] ecnt);
    vec_t v;
    v.s = '{rst, vld, op, idx, beq, bgt, we, wa, wd};
    v.e = '{ejen, etgt, efl, eeq, egt, ecnt};
    return v;
  endfunction

  task automatic drive(input stim_t s, input logic [12:0] pc);
    Reset       = s.rst;
    instr_valid = s.vld;
    OP          = s.op;
    PC          = pc;
    tgt_idx     = s.idx;
    BEQ         = s.beq;
    BGT         = s.bgt;
    lut_wr_en   = s.we;
    lut_wr_addr = s.wa;
    lut_wr_data = s.wd;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  exp_t e;
  stim_t s;
  int pulses;
  logic [4:0] exp_j;
  logic [4:0] exp_f;

  initial begin
    //            rst vld op  idx beq bgt we wa wd      | jen tgt     fl eq gt cnt
    tbl[0]  = mk(1, 0, NOP, 0, 0, 0, 0, 0, 0,          0, 0,       0, 0, 0, 0);
    tbl[1]  = mk(0, 0, NOP, 0, 0, 0, 1, 3, 13'h0123,   0, 0,       0, 0, 0, 0);
    tbl[2]  = mk(0, 0, NOP, 0, 0, 0, 1, 2, 13'h0040,   0, 0,       0, 0, 0, 0);
    tbl[3]  = mk(0, 1, JMP, 3, 0, 0, 0, 0, 0,          1, 13'h0123, 1, 0, 0, 1);
    tbl[4]  = mk(0, 1, JMP, 2, 0, 0, 0, 0, 0,          0, 13'h0123, 0, 0, 0, 1);
    tbl[5]  = mk(0, 1, CMP, 0, 1, 0, 0, 0, 0,          0, 13'h0123, 0, 1, 0, 1);
    tbl[6]  = mk(0, 1, BQ,  2, 0, 0, 0, 0, 0,          1, 13'h0040, 1, 1, 0, 2);
    tbl[7]  = mk(0, 1, NOP, 0, 0, 0, 0, 0, 0,          0, 13'h0040, 0, 1, 0, 2);
    tbl[8]  = mk(0, 1, BG,  3, 0, 0, 0, 0, 0,          0, 13'h0040, 0, 1, 0, 2);
    tbl[9]  = mk(0, 1, CMP, 0, 0, 1, 0, 0, 0,          0, 13'h0040, 0, 0, 1, 2);
    tbl[10] = mk(0, 1, BQ,  3, 0, 0, 0, 0, 0,          0, 13'h0040, 0, 0, 1, 2);
    tbl[11] = mk(0, 1, BG,  3, 0, 0, 0, 0, 0,          1, 13'h0123, 1, 0, 1, 3);
    tbl[12] = mk(0, 0, NOP, 0, 0, 0, 0, 0, 0,          0, 13'h0123, 0, 0, 1, 3);
    tbl[13] = mk(0, 1, JMP, 5, 0, 0, 1, 5, 13'h1ABC,   1, 13'h1ABC, 1, 0, 1, 4);
    tbl[14] = mk(0, 0, NOP, 0, 0, 0, 0, 0, 0,          0, 13'h1ABC, 0, 0, 1, 4);
    tbl[15] = mk(1, 1, JMP, 3, 0, 0, 0, 0, 0,          0, 0,       0, 0, 0, 0);
    tbl[16] = mk(0, 0, NOP, 0, 0, 0, 0, 0, 0,          0, 0,       0, 0, 0, 0);
    tbl[17] = mk(0, 1, JMP, 3, 0, 0, 0, 0, 0,          1, 0,       1, 0, 0, 1);
    tbl[18] = mk(0, 1, CMP, 0, 1, 1, 0, 0, 0,          0, 0,       0, 0, 0, 1);
    tbl[19] = mk(0, 1, CMP, 0, 1, 1, 0, 0, 0,          0, 0,       0, 1, 1, 1);

    s = '{1'b1, 1'b0, NOP, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 13'd0};
    drive(s, 13'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(tbl[i].s, 13'd0);
      sb.push_back(tbl[i].e);
      step();
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_jump_en", i), 32'(jen0), 32'(e.jen));
        check($sformatf("v%0d_target", i),  32'(tgt0), 32'(e.tgt));
        check($sformatf("v%0d_flush", i),   32'(fl0),  32'(e.fl));
        check($sformatf("v%0d_eq", i),      32'(eq0),  32'(e.eq));
        check($sformatf("v%0d_gt", i),      32'(gt0),  32'(e.gt));
        check($sformatf("v%0d_cnt", i),     32'(cnt0), 32'(e.cnt));
      end
    end

    // Three-cycle flush window with a continuous jump stream.
    @(negedge CLK);
    s = '{1'b1, 1'b0, NOP, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 13'd0};
    drive(s, 13'd0);
    step();
    @(negedge CLK);
    s = '{1'b0, 1'b0, NOP, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 13'h0123};
    drive(s, 13'd0);
    step();
    @(negedge CLK);
    s = '{1'b0, 1'b1, JMP, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 13'd0};
    drive(s, 13'd0);
    exp_j  = 5'b10001;
    exp_f  = 5'b10111;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4 && jen1) pulses++;
      check($sformatf("f3_jen_%0d", k), 32'(jen1), 32'(exp_j[k]));
      check($sformatf("f3_flush_%0d", k), 32'(fl1), 32'(exp_f[k]));
    end
    check("f3_pulses", 32'(pulses), 32'd1);
    check("f3_cnt", 32'(cnt1), 32'd2);
    check("f3_tgt", 32'(tgt1), 32'h0123);
    @(negedge CLK);
    instr_valid = 1'b0;
    step();

    // Odd-PC gating of unconditional jumps.
    @(negedge CLK);
    instr_valid = 1'b1;
    OP          = JMP;
    tgt_idx     = 4'd3;
    PC          = 13'h0010;
    step();
    check("odd_even_jen", 32'(jen2), 32'd0);
    check("odd_even_cnt", 32'(cnt2), 32'd0);
    @(negedge CLK);
    PC = 13'h0011;
    step();
    check("odd_odd_jen", 32'(jen2), 32'd1);
    check("odd_odd_tgt", 32'(tgt2), 32'h0123);
    check("odd_odd_cnt", 32'(cnt2), 32'd1);
    @(negedge CLK);
    instr_valid = 1'b0;
    PC          = 13'd0;
    step();

    // 16 taken jumps wrap a 4-bit counter.
    @(negedge CLK);
    Reset = 1'b1;
    step();
    check("wrap_reset_cnt", 32'(cnt3), 32'd0);
    @(negedge CLK);
    Reset       = 1'b0;
    instr_valid = 1'b1;
    OP          = JMP;
    tgt_idx     = 4'd0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (i == 15) check("wrap_cnt8", 32'(cnt3), 32'd8);
      if (i == 29) check("wrap_cnt15", 32'(cnt3), 32'd15);
    end
    check("wrap_cnt0", 32'(cnt3), 32'd0);
    @(negedge CLK);
    instr_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
